// File: rtl/filter_cascade.sv
// Cascade of one-pole IIR low-pass stages sharing a single multiplier.
// A sequencer walks the stages one per clock using a pre-sample state snapshot.
module filter_cascade #(
    parameter int              WIDTH      = 16,
    parameter int              STAGES     = 3,
    parameter int              COEF_W     = 16,
    parameter logic [COEF_W-1:0] COEF_RESET = 'h099b,
    localparam int             AW         = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     clkEn,
    input  logic signed [WIDTH-1:0]  iIn,
    input  logic                     iBypass,
    input  logic                     iCoefWe,
    input  logic [AW-1:0]            iCoefAddr,
    input  logic signed [COEF_W-1:0] iCoefData,
    output logic signed [WIDTH-1:0]  oOut,
    output logic                     oValid,
    output logic                     oBusy,
    output logic                     oOverrun
);

    localparam int P = COEF_W + WIDTH + 1;
    localparam logic signed [P-1:0] SMAX = P'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [P-1:0] SMIN = -SMAX - P'(1);
    localparam logic [AW:0] NST = (AW + 1)'(STAGES);
    localparam logic [AW-1:0] KLAST = AW'(STAGES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic signed [WIDTH-1:0]  s_q      [STAGES];
    logic signed [WIDTH-1:0]  sold_q   [STAGES];
    logic signed [COEF_W-1:0] coef_q   [STAGES];
    logic signed [COEF_W-1:0] shadow_q [STAGES];
    logic signed [WIDTH-1:0]  uin      [STAGES];
    logic signed [WIDTH-1:0]  x_q;
    logic [AW-1:0]            k_q;
    logic signed [WIDTH-1:0]  out_q;
    logic                     valid_q;
    logic                     ovr_q;

    logic                     start;
    logic                     byp_load;
    logic                     drop;
    logic                     last;

    logic signed [WIDTH-1:0]  u;
    logic signed [WIDTH-1:0]  so;
    logic signed [WIDTH:0]    diff;
    logic signed [P-1:0]      prod;
    logic signed [P-1:0]      sum;
    logic signed [WIDTH-1:0]  sat;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        oBusy    = (state_q == RUN);
        start    = (state_q == IDLE) && clkEn && !iBypass;
        byp_load = (state_q == IDLE) && clkEn && iBypass;
        drop     = clkEn && (state_q != IDLE);
        last     = (state_q == RUN) && (k_q == KLAST);
        oOut     = out_q;
        oValid   = valid_q;
        oOverrun = ovr_q;
    end

    // Stage k reads its upstream neighbour's pre-sample value, so the
    // sequential walk matches a parallel update of every stage.
    always_comb begin
        uin[0] = x_q;
        for (int k = 1; k < STAGES; k++) begin
            uin[k] = sold_q[k-1];
        end
    end

    always_comb begin
        u    = uin[k_q];
        so   = sold_q[k_q];
        diff = (WIDTH + 1)'(u) - (WIDTH + 1)'(so);
        prod = P'(shadow_q[k_q]) * P'(diff);
        sum  = (prod >>> (COEF_W - 1)) + P'(so);
        if (sum > SMAX) begin
            sat = SMAX[WIDTH-1:0];
        end else if (sum < SMIN) begin
            sat = SMIN[WIDTH-1:0];
        end else begin
            sat = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int k = 0; k < STAGES; k++) begin
                s_q[k]      <= '0;
                sold_q[k]   <= '0;
                coef_q[k]   <= COEF_RESET;
                shadow_q[k] <= COEF_RESET;
            end
            x_q     <= '0;
            k_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= drop;
            if (iCoefWe && ({1'b0, iCoefAddr} < NST)) begin
                coef_q[iCoefAddr] <= iCoefData;
            end
            if (start) begin
                x_q      <= iIn;
                k_q      <= '0;
                shadow_q <= coef_q;
                sold_q   <= s_q;
            end
            if (byp_load) begin
                out_q   <= iIn;
                valid_q <= 1'b1;
                for (int k = 0; k < STAGES; k++) begin
                    s_q[k] <= iIn;
                end
            end
            if (state_q == RUN) begin
                s_q[k_q] <= sat;
                k_q      <= k_q + 1'b1;
                if (last) begin
                    out_q   <= sat;
                    valid_q <= 1'b1;
                end
            end
        end
    end

endmodule
